// File: rtl/eh2_btb_upd_pkg.sv
// Shared types for the BTB write-port scheduler: FSM state, per-thread update
// request record and the BTB geometry it is built around.
package eh2_btb_upd_pkg;

    localparam int EH2_IDX_W  = 8;
    localparam int EH2_BTAG_W = 5;
    localparam int EH2_DATA_W = 22;
    localparam int BTB_SETS   = 2**EH2_IDX_W;

    typedef enum logic {INIT, ARB} eh2_btb_upd_state_t;

    typedef struct packed {
        logic [EH2_IDX_W-1:0]  index;
        logic [EH2_BTAG_W-1:0] tag;
        logic [EH2_DATA_W-1:0] data;
        logic                  set;
    } eh2_btb_upd_req_t;

endpackage

// File: rtl/eh2_btb_upd_rr_arb.sv
// Two-requester round-robin arbiter; the priority pointer flips only when both
// requesters contend and the grant is actually consumed (advance).
module eh2_btb_upd_rr_arb (
    input  logic       clk,
    input  logic       rst_l,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic r_prio;

    always_comb begin
        grant = '0;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant[r_prio] = 1'b1;
            default: grant = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_prio <= 1'b0;
        end else if (advance && (&req)) begin
            r_prio <= ~r_prio;
        end
    end

endmodule

// File: rtl/eh2_btb_upd_sched.sv
// BTB write-port scheduler: invalidate sweep after reset/flush, then per-thread
// one-entry hold registers drained through a round-robin arbiter.
// Optional per-thread stall counters: define RV_BTB_UPD_STALL_CNT_EN.
module eh2_btb_upd_sched
    import eh2_btb_upd_pkg::*;
#(
    parameter int BTB_ADDR_HI   = 9,
    parameter int BTB_ADDR_LO   = 2,
    parameter int BTB_BTAG_SIZE = 5,
    parameter int DATA_W        = 22,
    localparam int IDX_W        = BTB_ADDR_HI - BTB_ADDR_LO + 1
) (
    input  logic                          clk,
    input  logic                          rst_l,
    input  logic                          init_req,
    input  logic [1:0]                    upd_valid,
    output logic [1:0]                    upd_ready,
    input  logic [1:0][IDX_W-1:0]         upd_index,
    input  logic [1:0][BTB_BTAG_SIZE-1:0] upd_tag,
    input  logic [1:0][DATA_W-1:0]        upd_data,
    input  logic [1:0]                    upd_set,
    output logic                          wr_en,
    output logic [IDX_W-1:0]              wr_index,
    output logic [BTB_BTAG_SIZE-1:0]      wr_tag,
    output logic [DATA_W-1:0]             wr_data,
    output logic                          wr_vld,
    output logic                          wr_tid,
    output logic                          init_busy
`ifdef RV_BTB_UPD_STALL_CNT_EN
    ,
    output logic [1:0][15:0]              stall_cnt
`endif
);

    eh2_btb_upd_state_t     r_state;
    logic [IDX_W-1:0]       r_cnt;
    eh2_btb_upd_req_t [1:0] r_hold;
    logic [1:0]             r_hold_v;

    logic                   w_arb_go;
    logic [1:0]             w_grant;
    logic [1:0]             w_gnt;
    logic [1:0]             w_ready;
    logic [1:0]             w_accept;
    logic                   w_gtid;
    eh2_btb_upd_req_t       w_sel;

    // A flush request in ARB kills the grant and closes both inputs this cycle.
    assign w_arb_go = (r_state == ARB) && !init_req;
    assign w_gnt    = w_grant & {2{w_arb_go}};
    assign w_ready  = {2{w_arb_go}} & (~r_hold_v | w_grant);
    assign w_accept = upd_valid & w_ready;
    assign w_gtid   = w_grant[1];
    assign w_sel    = r_hold[w_gtid];

    eh2_btb_upd_rr_arb u_arb (
        .clk     (clk),
        .rst_l   (rst_l),
        .req     (r_hold_v),
        .advance (w_arb_go),
        .grant   (w_grant)
    );

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state  <= INIT;
            r_cnt    <= '0;
            r_hold_v <= '0;
        end else begin
            unique case (r_state)
                INIT: begin
                    r_hold_v <= '0;
                    if (init_req) begin
                        r_cnt <= '0;
                    end else if (&r_cnt) begin
                        r_state <= ARB;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ARB: begin
                    if (init_req) begin
                        r_state  <= INIT;
                        r_cnt    <= '0;
                        r_hold_v <= '0;
                    end else begin
                        r_hold_v <= w_accept | (r_hold_v & ~w_gnt);
                    end
                end
                default: r_state <= INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned t = 0; t < 2; t++) begin
            if (w_accept[t]) begin
                r_hold[t].index <= upd_index[t];
                r_hold[t].tag   <= upd_tag[t];
                r_hold[t].data  <= upd_data[t];
                r_hold[t].set   <= upd_set[t];
            end
        end
    end

    always_comb begin
        wr_en     = 1'b0;
        wr_index  = '0;
        wr_tag    = '0;
        wr_data   = '0;
        wr_vld    = 1'b0;
        wr_tid    = 1'b0;
        upd_ready = '0;
        init_busy = 1'b1;
        if (rst_l) begin
            init_busy = (r_state == INIT);
            if (r_state == INIT) begin
                wr_en    = 1'b1;
                wr_index = r_cnt;
            end else begin
                upd_ready = w_ready;
                wr_en     = |w_gnt;
                wr_index  = w_sel.index;
                wr_tag    = w_sel.tag;
                wr_data   = w_sel.data;
                wr_vld    = w_sel.set;
                wr_tid    = w_gtid;
            end
        end
    end

`ifdef RV_BTB_UPD_STALL_CNT_EN
    logic [1:0][15:0] r_stall;

    always_ff @(posedge clk) begin
        for (int unsigned t = 0; t < 2; t++) begin
            if (!rst_l || init_req) begin
                r_stall[t] <= '0;
            end else if ((r_state == ARB) && r_hold_v[t] && !w_grant[t] && (r_stall[t] != '1)) begin
                r_stall[t] <= r_stall[t] + 1'b1;
            end
        end
    end

    assign stall_cnt = r_stall;
`endif

endmodule
